iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 31 +++
 rtl/iter_alu_if.sv | 30 +++
 rtl/alu_comb.sv | 34 +++
 rtl/iter_alu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
// Holds the default operand width, the op-code enum and the FSM state enum.
// Optional feature macro: ITER_ALU_MUL_EN adds the S_MUL state.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LSL = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } op_e;

`ifdef ITER_ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

    // Ops that finish straight from IDLE through the combinational unit.
    function automatic logic op_is_single(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU.
// master (requester): drives start, op, a, b; receives busy, done, result,
//                     c, z, flg_c_ld, flg_z_ld, illegal.
// slave  (ALU):       the mirror image.
interface iter_alu_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c;
    logic             z;
    logic             flg_c_ld;
    logic             flg_z_ld;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, c, z, flg_c_ld, flg_z_ld, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, c, z, flg_c_ld, flg_z_ld, illegal
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle part of the ALU: ADD, SUB, AND, OR, XOR.
// Ports: i_op operation, i_a/i_b operands, o_y result, o_c carry/borrow.
// Other op codes produce zero; the caller never uses them.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;

    // Extra top bit of the difference is the borrow (set when a < b).
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_y = '0;
        o_c = 1'b0;
        case (i_op)
            OP_ADD:  {o_c, o_y} = w_sum;
            OP_SUB:  {o_c, o_y} = w_dif;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: ;
        endcase
    end
endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial LSL and an
// optional shift-add multiplier, reporting C/Z flag values with load enables.
// Ports: clk (rising edge), reset (async, active high), bus (iter_alu_if.slave).
// Macro ITER_ALU_MUL_EN: when defined, op 110 is a WIDTH-cycle multiply;
// otherwise op 110 is treated as illegal and no multiplier is built.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    iter_alu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef ITER_ALU_MUL_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    state_e           r_state;
    state_e           w_state_next;
    op_e              w_op;
    logic             w_illegal;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_z;
    logic             r_illegal;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_alu_c;
    logic [WIDTH-1:0] w_shift_y;
    logic             w_shift_c;

    assign w_op = op_e'(bus.op);

`ifdef ITER_ALU_MUL_EN
    logic [ACC_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [ACC_W-1:0] w_mul_sum;
    assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_illegal = (w_op == OP_ILL);
`else
    assign w_illegal = (w_op == OP_ILL) || (w_op == OP_MUL);
`endif

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .i_op (w_op),
        .i_a  (bus.a),
        .i_b  (bus.b),
        .o_y  (w_alu_y),
        .o_c  (w_alu_c)
    );

    // A zero shift count spends one SHIFT cycle doing nothing (carry 0);
    // otherwise each cycle moves one bit out of the top.
    assign w_shift_y = (r_cnt == '0) ? r_acc[WIDTH-1:0] : {r_acc[WIDTH-2:0], 1'b0};
    assign w_shift_c = (r_cnt == '0) ? 1'b0 : r_acc[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_op == OP_LSL)      w_state_next = S_SHIFT;
`ifdef ITER_ALU_MUL_EN
                    else if (w_op == OP_MUL) w_state_next = S_MUL;
`endif
                    else                     w_state_next = S_DONE;
                end
            end
            S_SHIFT: if (r_cnt <= CNT_W'(1)) w_state_next = S_DONE;
`ifdef ITER_ALU_MUL_EN
            S_MUL:   if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath. result/c/z only change on the edge that enters DONE, so they
    // stay stable between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ITER_ALU_MUL_EN
            r_mcand   <= '0;
            r_mplier  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_illegal <= w_illegal;
                        r_cnt     <= CNT_W'(bus.b[2:0]);
                        r_acc     <= ACC_W'(bus.a);
`ifdef ITER_ALU_MUL_EN
                        r_mcand   <= ACC_W'(bus.a);
                        r_mplier  <= bus.b;
                        if (w_op == OP_MUL) begin
                            r_cnt <= CNT_W'(WIDTH);
                            r_acc <= '0;
                        end
`endif
                        if (op_is_single(w_op)) begin
                            r_result <= w_alu_y;
                            r_c      <= w_alu_c;
                            r_z      <= (w_alu_y == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc[WIDTH-1:0] <= w_shift_y;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_result <= w_shift_y;
                        r_c      <= w_shift_c;
                        r_z      <= (w_shift_y == '0);
                    end
                end
`ifdef ITER_ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= {r_mcand[ACC_W-2:0], 1'b0};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_mul_sum[WIDTH-1:0];
                        r_c      <= |w_mul_sum[ACC_W-1:WIDTH];
                        r_z      <= (w_mul_sum[WIDTH-1:0] == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.flg_c_ld = (r_state == S_DONE) && !r_illegal;
    assign bus.flg_z_ld = (r_state == S_DONE) && !r_illegal;
    assign bus.illegal  = (r_state == S_DONE) && r_illegal;
    assign bus.result   = r_result;
    assign bus.c        = r_c;
    assign bus.z        = r_z;
endmodule
